// File: rtl/fila_pkg.sv
// fila_pkg -- shared constants and helpers for the fila_param FIFO.
//
// Contents:
//   FILA_DEF_WIDTH / FILA_DEF_DEPTH : default data width and entry count
//   ptr_width(depth)                : bits needed to address 'depth' entries
//   len_width(depth)                : bits needed to hold an occupancy of 0..depth
package fila_pkg;

    localparam int unsigned FILA_DEF_WIDTH = 8;
    localparam int unsigned FILA_DEF_DEPTH = 8;

    // Pointer width; depth is a power of two, so pointers wrap by plain overflow.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy needs one bit more than a pointer so that 'depth' itself is representable.
    function automatic int unsigned len_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fila_ram.sv
// fila_ram -- DEPTH x WIDTH storage for the fila_param FIFO.
//
// One synchronous write port and one registered read port sharing one clock.
// The read register only loads when rd_en is high, so it holds the last word
// read otherwise. A read and a write to the same address on the same edge
// returns the old contents. Neither the array nor the read register is reset.
//
// Ports:
//   clock    in   clock
//   wr_en    in   write strobe
//   wr_addr  in   write address
//   wr_data  in   word to write
//   rd_en    in   read strobe (loads rd_data)
//   rd_addr  in   read address
//   rd_data  out  registered read data
module fila_ram
    import fila_pkg::*;
#(
    parameter int unsigned WIDTH = FILA_DEF_WIDTH,
    parameter int unsigned DEPTH = FILA_DEF_DEPTH,
    localparam int unsigned AW = ptr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fila_param.sv
// fila_param -- parameterised synchronous FIFO with registered read data,
// occupancy count, status flags and sticky overflow/underflow errors.
//
// Ports:
//   clock             in   clock, rising edge
//   reset             in   asynchronous, active-high reset
//   data_in           in   word to enqueue
//   enqueue_in        in   enqueue request
//   dequeue_in        in   dequeue request
//   flush_in          in   synchronous clear (wins over enqueue/dequeue)
//   data_out          out  last dequeued word
//   valid_out         out  one-cycle strobe: data_out updated on the last edge
//   len_out           out  occupancy 0..DEPTH
//   full_out          out  len_out == DEPTH
//   empty_out         out  len_out == 0
//   almost_full_out   out  len_out >= AF_LEVEL
//   almost_empty_out  out  len_out <= AE_LEVEL
//   overflow_out      out  sticky: an enqueue was refused
//   underflow_out     out  sticky: a dequeue was refused
module fila_param
    import fila_pkg::*;
#(
    parameter int unsigned WIDTH    = FILA_DEF_WIDTH,
    parameter int unsigned DEPTH    = FILA_DEF_DEPTH,
    parameter int unsigned AF_LEVEL = DEPTH - 1,
    parameter int unsigned AE_LEVEL = 1,
    localparam int unsigned LW = len_width(DEPTH),
    localparam int unsigned PW = ptr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    input  logic             dequeue_in,
    input  logic             flush_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [LW-1:0]    len_out,
    output logic             full_out,
    output logic             empty_out,
    output logic             almost_full_out,
    output logic             almost_empty_out,
    output logic             overflow_out,
    output logic             underflow_out
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] len_q, len_d;
    logic          valid_q, valid_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    // Set by the first accepted dequeue after reset. The RAM read register
    // has no reset, so data_out reads as zero until it has been loaded.
    logic          primed_q, primed_d;

    logic          enq_ok;
    logic          deq_ok;
    logic          is_full;
    logic          is_empty;

    logic [WIDTH-1:0] ram_rd_data;

    // ------------------------------------------------------------------
    // Status, derived from the registered count only
    // ------------------------------------------------------------------
    assign is_full  = (len_q == LW'(DEPTH));
    assign is_empty = (len_q == '0);

    assign len_out          = len_q;
    assign full_out         = is_full;
    assign empty_out        = is_empty;
    assign almost_full_out  = (len_q >= LW'(AF_LEVEL));
    assign almost_empty_out = (len_q <= LW'(AE_LEVEL));
    assign valid_out        = valid_q;
    assign overflow_out     = ovf_q;
    assign underflow_out    = unf_q;
    assign data_out         = primed_q ? ram_rd_data : '0;

    // ------------------------------------------------------------------
    // Accept decisions
    // ------------------------------------------------------------------
    // An empty FIFO never bypasses: a dequeue needs a word already stored.
    // When full, a simultaneous dequeue frees the slot the enqueue takes.
    always_comb begin
        deq_ok = ~flush_in & dequeue_in & ~is_empty;
        enq_ok = ~flush_in & enqueue_in & (~is_full | deq_ok);
    end

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        valid_d  = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        primed_d = primed_q | deq_ok;

        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            len_d    = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            if (enq_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq_ok) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                valid_d  = 1'b1;
            end

            unique case ({enq_ok, deq_ok})
                2'b10:   len_d = len_q + LW'(1);
                2'b01:   len_d = len_q - LW'(1);
                default: len_d = len_q;
            endcase

            if (enqueue_in && !enq_ok) begin
                ovf_d = 1'b1;
            end
            if (dequeue_in && !deq_ok) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            primed_q <= primed_d;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    fila_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (enq_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (deq_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

endmodule

// File: doc/fila_param.md
FILA_PARAM -- requirements
Module: fila_param

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 8, number of entries (power of two, >=2).
REQ-003 Parameter AF_LEVEL, default DEPTH-1, almost_full threshold (1..DEPTH).
REQ-004 Parameter AE_LEVEL, default 1, almost_empty threshold (0..DEPTH-1).
REQ-005 clock  input  1  clock; all state changes on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-high.
REQ-007 data_in  input  WIDTH  word to enqueue.
REQ-008 enqueue_in  input  1  enqueue request, sampled each rising edge.
REQ-009 dequeue_in  input  1  dequeue request, sampled each rising edge.
REQ-010 flush_in  input  1  synchronous clear of contents and sticky flags.
REQ-011 data_out  output  WIDTH  last dequeued word, registered.
REQ-012 valid_out  output  1  one-cycle strobe: data_out updated this cycle.
REQ-013 len_out  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-014 full_out / empty_out  output  1 each  len_out==DEPTH / len_out==0.
REQ-015 almost_full_out / almost_empty_out  output  1 each  len_out>=AF_LEVEL / len_out<=AE_LEVEL.
REQ-016 overflow_out / underflow_out  output  1 each  sticky error flags.

Function
REQ-017 Accept dequeue (deq_ok) when dequeue_in=1 and len_out>0.
REQ-018 Accept enqueue (enq_ok) when enqueue_in=1 and (len_out<DEPTH or deq_ok); full with both requests: both accepted, len_out stays DEPTH.
REQ-019 Empty with both requests: enqueue accepted, dequeue rejected (no bypass), underflow_out set, valid_out=0.
REQ-020 enq_ok: write data_in at write pointer; write pointer +1 modulo DEPTH.
REQ-021 deq_ok: data_out <= entry at read pointer, valid_out=1 next cycle, read pointer +1 modulo DEPTH; otherwise valid_out=0 and data_out holds.
REQ-022 len_out next = len_out + enq_ok - deq_ok; simultaneous accept leaves len_out unchanged.
REQ-023 Read latency: data_out/valid_out valid on the edge that accepts the dequeue (visible 1 cycle after request sampled).
REQ-024 Word written at edge N is dequeueable at edge N+1 at earliest.
REQ-025 Enqueue rejected (full, no deq_ok): overflow_out set to 1, storage, pointers, len_out unchanged.
REQ-026 Dequeue rejected (empty): underflow_out set to 1, data_out unchanged.
REQ-027 overflow_out/underflow_out stay 1 until flush_in or reset.
REQ-028 flush_in=1 has priority over enqueue/dequeue that cycle: pointers=0, len_out=0, valid_out=0, sticky flags=0; data_out holds; storage contents need not clear.
REQ-029 Status outputs (full, empty, almost_*) derived combinationally from registered len_out only.
REQ-030 Pointer wrap DEPTH-1 -> 0 without bubble or data loss.

Reset
REQ-031 reset=1 immediately forces: pointers=0, len_out=0, data_out=0, valid_out=0, overflow_out=0, underflow_out=0.
REQ-032 Reset mid-operation discards all queued words; first edge after release behaves as empty FIFO.
REQ-033 Storage array not required to reset.

Structure
REQ-034 Package fila_pkg holds default WIDTH/DEPTH constants and a function computing len_out width.
REQ-035 Sub-module fila_ram: DEPTH x WIDTH array, one synchronous write port, one registered read port, no reset.
REQ-036 Control (pointers, counter, flags) in fila_param; no latches, single clock domain.

Verification
REQ-037 Fill: reset, enqueue 0x11..0x18 (8 cycles) -> len_out=8, full_out=1, almost_full_out=1, overflow_out=0; 9th enqueue 0x99 -> overflow_out=1, len_out=8.
REQ-038 Drain: from full, dequeue 8 cycles -> data_out 0x11..0x18 in order, valid_out=1 each cycle, empty_out=1; 9th dequeue -> underflow_out=1, data_out=0x18.
REQ-039 Simultaneous: at len_out=8 enqueue 0xA5 and dequeue -> len_out=8, 0xA5 emerges after 8 further dequeues; at len_out=0 both -> len_out=1, underflow_out=1.
REQ-040 Wrap: 20 interleaved enqueue/dequeue of incrementing bytes with len_out between 3 and 5 -> output sequence equals input sequence, no flags set.
REQ-041 Flush/reset: at len_out=5 with overflow_out=1 assert flush_in with enqueue_in -> len_out=0, overflow_out=0, nothing enqueued; mid-stream reset -> all outputs 0 asynchronously.
REQ-042 Parameter sweep: WIDTH=16/DEPTH=4 and WIDTH=1/DEPTH=32 with AF_LEVEL/AE_LEVEL thresholds -> almost flags toggle exactly at thresholds.
